// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//   Shares one APB master port among NUM_REQ local requesters. Requests are
//   granted round-robin. Each granted request runs one APB SETUP/ACCESS
//   transfer. The transfer waits on pready, and a timeout can force it to
//   complete. The response is routed back to the requester that owns it.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   req_valid/ready     per-requester handshake (ready is a one-hot pulse)
//   req_addr/write/     per-requester request fields, packed and sliced by
//   req_wdata/strb/prot requester index
//   rsp_valid           one-hot completion pulse to the owning requester
//   rsp_rdata/rsp_err   read data and error flag, valid with rsp_valid
//   paddr..pstrb        APB master outputs
//   pready/prdata/      APB slave response inputs
//   pslverr
module apb_master_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_strb,
    input  logic [NUM_REQ-1:0]                 req_prot,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic                               rsp_err,
    output logic [ADDR_WIDTH-1:0]              paddr,
    output logic                               pprot,
    output logic                               psel,
    output logic                               penable,
    output logic                               pwrite,
    output logic [DATA_WIDTH-1:0]              pwdata,
    output logic [DATA_WIDTH/8-1:0]            pstrb,
    input  logic                               pready,
    input  logic [DATA_WIDTH-1:0]              prdata,
    input  logic                               pslverr
);

    localparam int          STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned NREQ       = NUM_REQ;
    localparam int          PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          TMO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_e;

    state_e state_q, state_d;

    logic [PTR_W-1:0]      ptr_q;
    logic [PTR_W-1:0]      owner_q;
    logic [TMO_W-1:0]      tmo_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic                  prot_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    logic [PTR_W-1:0]      scan_idx;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_found;
    logic                  arb_en;
    logic                  accept;
    logic                  complete;
    logic                  tmo_hit;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_WIDTH-1:0] sel_strb;
    logic                  sel_write;
    logic                  sel_prot;

    // Round-robin search: first valid requester after the last winner.
    always_comb begin
        scan_idx    = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan_idx = PTR_W'((32'(ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Request fields of the current winner.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        sel_write = 1'b0;
        sel_prot  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb  = req_strb[i*STRB_WIDTH +: STRB_WIDTH];
                sel_write = req_write[i];
                sel_prot  = req_prot[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        psel     = 1'b0;
        penable  = 1'b0;
        arb_en   = 1'b0;
        complete = 1'b0;
        tmo_hit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                arb_en = 1'b1;
                if (grant_found) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel    = 1'b1;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    // Normal completion re-arbitrates so a waiting request
                    // goes straight to SETUP without an idle cycle.
                    complete = 1'b1;
                    arb_en   = 1'b1;
                    state_d  = grant_found ? ST_SETUP : ST_IDLE;
                end else if ((TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST)) begin
                    // Forced completion always releases the bus.
                    complete = 1'b1;
                    tmo_hit  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = arb_en & grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q       <= PTR_RST;
            owner_q     <= '0;
            tmo_cnt_q   <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            prot_q      <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                ptr_q   <= grant_idx;
                owner_q <= grant_idx;
                addr_q  <= sel_addr;
                write_q <= sel_write;
                prot_q  <= sel_prot;
                // Reads drive zero data/strobes on the bus.
                wdata_q <= sel_write ? sel_wdata : '0;
                strb_q  <= sel_write ? sel_strb : '0;
            end

            if (complete) begin
                tmo_cnt_q <= '0;
            end else if (state_q == ST_ACCESS) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end

            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            if (complete) begin
                rsp_valid_q[owner_q] <= 1'b1;
                rsp_err_q            <= tmo_hit | pslverr;
                rsp_rdata_q          <= (!write_q && !tmo_hit) ? prdata : '0;
            end
        end
    end

    assign paddr     = addr_q;
    assign pwrite    = write_q;
    assign pprot     = prot_q;
    assign pwdata    = wdata_q;
    assign pstrb     = strb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter
//   Self-checking bench for apb_master_arbiter (NUM_REQ=2, 32-bit, TIMEOUT=4).
//   A scripted APB slave answers transfers. An accept monitor pushes the
//   expected response per grant, and a response monitor pops and compares.
module tb_apb_master_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int TMO     = 4;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*AW-1:0]   req_addr = '0;
    logic [NUM_REQ-1:0]      req_write = '0;
    logic [NUM_REQ*DW-1:0]   req_wdata = '0;
    logic [NUM_REQ*SW-1:0]   req_strb = '0;
    logic [NUM_REQ-1:0]      req_prot = '0;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [DW-1:0]           rsp_rdata;
    logic                    rsp_err;
    logic [AW-1:0]           paddr;
    logic                    pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DW-1:0]           pwdata;
    logic [SW-1:0]           pstrb;
    logic                    pready = 1'b0;
    logic [DW-1:0]           prdata = '0;
    logic                    pslverr = 1'b0;

    apb_master_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_prot  (req_prot),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pprot     (pprot),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scripted slave: slv_waits low cycles of pready per ACCESS, or stuck low.
    int unsigned slv_waits = 0;
    int unsigned slv_cnt   = 0;
    logic        slv_stuck = 1'b0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err   = 1'b0;

    always @(posedge clk) begin
        #1;
        if (psel && penable && !slv_stuck) begin
            if (slv_cnt >= slv_waits) begin
                pready  = 1'b1;
                slv_cnt = 0;
            end else begin
                pready  = 1'b0;
                slv_cnt++;
            end
        end else begin
            pready = 1'b0;
            if (!(psel && penable)) slv_cnt = 0;
        end
        prdata  = slv_rdata;
        pslverr = slv_err;
    end

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   grant_q[$];
    exp_t mon_e;
    exp_t pop_e;
    int   cyc = 0;
    int   rsp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (req_ready != '0) begin
                check("ready_onehot", 64'($countones(req_ready)), 64'd1);
                check("ready_subset", 64'(req_ready & ~req_valid), 64'd0);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_e.id      = i;
                    mon_e.err     = slv_stuck | slv_err;
                    mon_e.rdata   = (req_write[i] || slv_stuck) ? 32'h0 : slv_rdata;
                    mon_e.lat     = slv_stuck ? (2 + TMO) : (3 + int'(slv_waits));
                    mon_e.acc_cyc = cyc;
                    exp_q.push_back(mon_e);
                    grant_q.push_back(i);
                end
            end
        end
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                pop_e = exp_q.pop_front();
                check("rsp_owner", 64'(rsp_valid), 64'(1) << pop_e.id);
                check("rsp_rdata", 64'(rsp_rdata), 64'(pop_e.rdata));
                check("rsp_err", 64'(rsp_err), 64'(pop_e.err));
                check("rsp_latency", 64'(cyc - pop_e.acc_cyc), 64'(pop_e.lat));
            end
            rsp_cnt++;
        end
    end

    // One request from one requester, checked through SETUP and ACCESS.
    task automatic run_single(input string tag, input int id, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic prot);
        int          guard;
        int          base;
        logic [31:0] exp_wd;
        logic [3:0]  exp_st;
        exp_wd = wr ? wdata : 32'h0;
        exp_st = wr ? strb : 4'h0;
        base   = rsp_cnt;
        @(posedge clk); #1;
        req_addr[id*AW +: AW]  = addr;
        req_wdata[id*DW +: DW] = wdata;
        req_strb[id*SW +: SW]  = strb;
        req_write[id]          = wr;
        req_prot[id]           = prot;
        req_valid[id]          = 1'b1;
        guard = 0;
        do begin
            @(negedge clk); #1;
            guard++;
        end while (!req_ready[id] && guard < 20);
        check({tag, "_accept"}, 64'(req_ready[id]), 64'd1);
        @(posedge clk); #1;
        // Scramble the request inputs: the bus must use the latched copy.
        req_valid[id]          = 1'b0;
        req_addr[id*AW +: AW]  = ~addr;
        req_wdata[id*DW +: DW] = ~wdata;
        req_strb[id*SW +: SW]  = ~strb;
        req_write[id]          = ~wr;
        req_prot[id]           = ~prot;
        @(negedge clk); #1;
        check({tag, "_setup_psel"}, 64'(psel), 64'd1);
        check({tag, "_setup_penable"}, 64'(penable), 64'd0);
        check({tag, "_paddr"}, 64'(paddr), 64'(addr));
        check({tag, "_pwrite"}, 64'(pwrite), 64'(wr));
        check({tag, "_pprot"}, 64'(pprot), 64'(prot));
        check({tag, "_pwdata"}, 64'(pwdata), 64'(exp_wd));
        check({tag, "_pstrb"}, 64'(pstrb), 64'(exp_st));
        guard = 0;
        while (rsp_cnt == base && guard < 40) begin
            @(negedge clk); #1;
            guard++;
            if (psel && penable) begin
                check({tag, "_access_paddr"}, 64'(paddr), 64'(addr));
                check({tag, "_access_pwdata"}, 64'(pwdata), 64'(exp_wd));
                check({tag, "_access_pstrb"}, 64'(pstrb), 64'(exp_st));
            end
        end
        check({tag, "_rsp"}, 64'(rsp_cnt - base), 64'd1);
        check({tag, "_idle_psel"}, 64'(psel), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int base;
        int g;

        repeat (3) @(negedge clk);
        #1;
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        check("rst_pstrb", 64'(pstrb), 64'd0);
        check("rst_pwrite", 64'(pwrite), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 1: zero-wait write from requester 0
        run_single("t1", 0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 1'b0);

        // 2: read from requester 1 with three wait states
        slv_waits = 3;
        slv_rdata = 32'hDEAD_BEEF;
        run_single("t2", 1, 1'b0, 32'h20, 32'h1111_2222, 4'hF, 1'b1);
        slv_waits = 0;

        // 3: both requesters continuously valid for four transfers
        grant_q.delete();
        base = rsp_cnt;
        slv_rdata = 32'h0C0F_FEE0;
        @(posedge clk); #1;
        req_addr  = {32'h0000_0104, 32'h0000_0100};
        req_wdata = {32'h0, 32'h5555_AAAA};
        req_strb  = {4'h0, 4'h3};
        req_write = 2'b01;
        req_prot  = 2'b00;
        req_valid = 2'b11;
        guard = 0;
        do begin
            @(negedge clk); #1;
            guard++;
        end while (req_ready == '0 && guard < 20);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            check("t3_psel", 64'(psel), 64'd1);
            check("t3_penable", 64'(penable), 64'(k % 2));
            if (k == 5) begin
                @(posedge clk); #1;
                req_valid = '0;
            end
        end
        check("t3_grants", 64'(grant_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            g = (k < grant_q.size()) ? grant_q[k] : -1;
            check("t3_grant_order", 64'(g), 64'(k % 2));
        end
        guard = 0;
        while (rsp_cnt < base + 4 && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        check("t3_rsp_count", 64'(rsp_cnt - base), 64'd4);

        // 4: slave error on a write, then a normal read
        slv_err = 1'b1;
        run_single("t4_err", 1, 1'b1, 32'h30, 32'h1234_5678, 4'h3, 1'b0);
        slv_err   = 1'b0;
        slv_rdata = 32'h0BAD_F00D;
        run_single("t4_next", 0, 1'b0, 32'h34, 32'h0, 4'h0, 1'b0);

        // 5: pready stuck low forces a timeout completion
        slv_stuck = 1'b1;
        slv_rdata = 32'h7777_7777;
        run_single("t5", 1, 1'b0, 32'h60, 32'h0, 4'h0, 1'b0);
        slv_stuck = 1'b0;

        // 6: reset during ACCESS of requester 0
        slv_stuck = 1'b1;
        @(posedge clk); #1;
        req_addr[0 +: AW] = 32'h40;
        req_write[0]      = 1'b0;
        req_valid[0]      = 1'b1;
        guard = 0;
        do begin
            @(negedge clk); #1;
            guard++;
        end while (!req_ready[0] && guard < 20);
        check("t6_accept", 64'(req_ready[0]), 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("t6_in_access", 64'(penable), 64'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        slv_stuck = 1'b0;
        @(negedge clk); #1;
        check("t6_rst_psel", 64'(psel), 64'd0);
        check("t6_rst_penable", 64'(penable), 64'd0);
        check("t6_rst_rsp", 64'(rsp_valid), 64'd0);
        exp_q.delete();
        grant_q.delete();
        base = rsp_cnt;
        @(posedge clk); #1;
        reset_n   = 1'b1;
        req_addr  = {32'h0000_0054, 32'h0000_0050};
        req_wdata = {32'hBBBB_0002, 32'hAAAA_0001};
        req_strb  = {4'hF, 4'hF};
        req_write = 2'b11;
        req_valid = 2'b11;
        guard = 0;
        while (grant_q.size() < 1 && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        check("t6_grant_seen", 64'(grant_q.size()), 64'd1);
        g = (grant_q.size() > 0) ? grant_q[0] : -1;
        check("t6_first_grant", 64'(g), 64'd0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        guard = 0;
        while (grant_q.size() < 2 && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        req_valid = '0;
        g = (grant_q.size() > 1) ? grant_q[1] : -1;
        check("t6_second_grant", 64'(g), 64'd1);
        guard = 0;
        while (rsp_cnt < base + 2 && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        check("t6_rsp_count", 64'(rsp_cnt - base), 64'd2);

        repeat (4) @(negedge clk);
        #1;
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Shares one APB master port among NUM_REQ local requesters. It arbitrates round-robin and sequences the APB SETUP/ACCESS phases. It also handles pready wait states, a completion timeout, and response routing. It sits between on-chip initiators (register-access engines, test sequencers) and an apb_interface master connection.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width (8, 16 or 32)
TIMEOUT, 16, max ACCESS cycles without pready before forced error completion; 0 disables timeout

Ports:
clk  in  1  clock, all logic on posedge
reset_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  request pending, one bit per requester
req_ready  out  NUM_REQ  request accepted (one-hot, one-cycle pulse)
req_addr  in  NUM_REQ*ADDR_WIDTH  address, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_write  in  NUM_REQ  1=write, 0=read
req_wdata  in  NUM_REQ*DATA_WIDTH  write data, sliced per requester
req_strb  in  NUM_REQ*DATA_WIDTH/8  write strobes, sliced per requester
req_prot  in  NUM_REQ  protection bit
rsp_valid  out  NUM_REQ  completion pulse to the owning requester (one-hot, one cycle)
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
rsp_err  out  1  error flag (pslverr or timeout), valid with rsp_valid
paddr  out  ADDR_WIDTH  APB address
pprot  out  1  APB protection
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB write strobes
pready  in  1  slave ready
prdata  in  DATA_WIDTH  slave read data
pslverr  in  1  slave error

Behaviour:
- Reset (reset_n=0 sampled at posedge): state=IDLE. All outputs 0. RR pointer=NUM_REQ-1, so requester 0 has top priority first. Timeout counter=0.
- Reset mid-transaction: the transaction is abandoned. psel/penable are 0 after the reset edge. No rsp_valid is issued for it.
- Request handshake: a request is accepted when req_valid[i] & req_ready[i]. Request fields must be stable while req_valid is high and unaccepted. The arbiter latches all fields on acceptance. The requester may change them or present a new request on the following cycle.
- Arbitration (combinational on req_valid, evaluated in IDLE and on the ACCESS completion cycle):
  - Winner is the first set bit searching from pointer+1 upward with wrap-around.
  - req_ready[winner]=1 that cycle. Pointer<=winner. Next state SETUP.
- States:
  - IDLE: psel=0, penable=0. Any req_valid -> accept winner -> SETUP. Otherwise stay in IDLE.
  - SETUP (exactly 1 cycle): psel=1, penable=0. paddr/pwrite/pprot/pwdata/pstrb come from the latched request. -> ACCESS.
  - ACCESS: psel=1, penable=1, all address/control/data held stable.
    - pready=1: complete.
    - pready=0: increment timeout counter. If TIMEOUT!=0 and counter==TIMEOUT-1 this cycle, force completion.
- Reads: pwdata=0, pstrb=0 (APB4 rule). Writes: pwdata/pstrb come from the request.
- Completion (registered, visible the cycle after the pready edge):
  - rsp_valid[owner]=1 for one cycle. rsp_err=pslverr.
  - rsp_rdata=prdata on reads; rsp_rdata=0 on writes.
  - Timeout completion: rsp_err=1, rsp_rdata=0, psel/penable drop.
  - The timeout counter clears on every completion.
- Back-to-back: on the completion cycle, arbitration runs with the updated pointer. If any req_valid is set, state goes straight to SETUP: psel stays 1 and penable drops to 0. Otherwise state goes to IDLE.
- Outputs when not selected: paddr/pwrite/pprot hold their last value. pwdata/pstrb hold their last value.
- Throughput: minimum 2 APB cycles per transfer. Latency from acceptance to rsp_valid is 3 cycles with zero wait states.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transfers.
- Only one transaction is outstanding at a time. req_ready is never asserted in SETUP, or in ACCESS before completion.

Test Plan:
1. Requester 0 writes addr 0x10, data 0xA5A5_0001, strb 0xF, pready tied high -> SETUP then ACCESS with penable; rsp_valid[0] 3 cycles after accept; rsp_err=0; rsp_rdata=0.
2. Requester 1 reads addr 0x20 with pready held low 3 ACCESS cycles, prdata=0xDEAD_BEEF -> paddr/psel stable throughout; pstrb=0; rsp_rdata=0xDEADBEEF on rsp_valid[1].
3. Both req_valid held high for 4 transfers, pready=1 -> grant order 0,1,0,1; psel continuous; penable alternates 0,1.
4. pslverr=1 with pready on a write from req 1 -> rsp_valid[1] with rsp_err=1; next request proceeds normally.
5. TIMEOUT=4, pready stuck low -> forced completion after 4 ACCESS cycles; rsp_err=1; rsp_rdata=0; psel=0 next cycle.
6. reset_n=0 asserted during ACCESS -> psel=penable=0 after edge; no rsp_valid; first grant after release goes to requester 0.
